// File: rtl/bit_serializer.sv
// Parallel-to-serial framer: 2-entry input FIFO feeding an MSB-first shifter, back-to-back frames without gaps.
// Optional even-parity bit per frame when PARITY_EN is defined; frame_count counts completed frames.
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             input_bit,
  output logic             bit_valid,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic             push, pop, fifo_nempty, frame_end;
  logic [WIDTH-1:0] head;

  assign fifo_nempty = (occ_q != 2'd0);
  assign head        = mem_q[rd_ptr_q];
  // Ready depends only on the registered occupancy, never on this cycle's pop.
  assign data_ready  = (occ_q != 2'd2);
  assign push        = data_valid & data_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    pop         = 1'b0;
    frame_end   = 1'b0;
`ifdef PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: ;
      SHIFT: begin
        shreg_d = shreg_q << 1;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
`ifdef PARITY_EN
          state_d = PARITY;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: frame_end = 1'b1;
`endif
      default: state_d = IDLE;
    endcase

    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      state_d     = IDLE;
    end

    // Loading on the frame-end edge keeps consecutive frames gap-free.
    if ((state_q == IDLE || frame_end) && fifo_nempty) begin
      pop     = 1'b1;
      shreg_d = head;
      idx_d   = '0;
      state_d = SHIFT;
`ifdef PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
`ifdef PARITY_EN
      par_q       <= 1'b0;
`endif
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef PARITY_EN
      par_q       <= par_d;
`endif
      occ_q       <= occ_d;
      if (push) begin
        mem_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_comb begin
    input_bit = 1'b0;
    case (state_q)
      SHIFT:  input_bit = shreg_q[WIDTH-1];
`ifdef PARITY_EN
      PARITY: input_bit = par_q;
`endif
      default: input_bit = 1'b0;
    endcase
  end

  assign bit_valid   = (state_q != IDLE);
  assign busy        = bit_valid | fifo_nempty;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: driver queues expected serial bits, a negedge monitor pops and compares.
module tb_bit_serializer;
  localparam int W = 8;
`ifdef PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         data_ready, input_bit, bit_valid, busy;
  logic [15:0]  frame_count;

  logic [1:0]   d2_in = '0;
  logic         d2_valid = 1'b0;
  logic         d2_ready, d2_bit, d2_bvld, d2_busy;
  logic [2:0]   d2_cnt;

  bit_serializer #(.WIDTH(W), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .input_bit(input_bit), .bit_valid(bit_valid),
    .busy(busy), .frame_count(frame_count)
  );

  bit_serializer #(.WIDTH(2), .CNT_W(3)) dut2 (
    .clock(clock), .reset(reset), .data_in(d2_in), .data_valid(d2_valid),
    .data_ready(d2_ready), .input_bit(d2_bit), .bit_valid(d2_bvld),
    .busy(d2_busy), .frame_count(d2_cnt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  bit exp_bit;
  int run = 0;
  int last_run = 0;

  // Hand-computed vectors: word and its even-parity bit.
  logic [W-1:0] vw [6] = '{8'hD5, 8'hA0, 8'h0F, 8'h33, 8'hFF, 8'h01};
  bit           vp [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      run = 0;
    end else if (bit_valid) begin
      run++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bit: got bit %0b with nothing expected", input_bit);
      end else begin
        exp_bit = exp_q.pop_front();
        check("serial_bit", {31'd0, input_bit}, {31'd0, exp_bit});
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
      check("idle_bit_zero", {31'd0, input_bit}, 32'd0);
    end
  end

  task automatic push_word(input int i);
    int t = 0;
    data_in    = vw[i];
    data_valid = 1'b1;
    while (!data_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!data_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %0h not accepted within %0d cycles", vw[i], t);
    end else begin
      for (int b = W - 1; b >= 0; b--) exp_q.push_back(vw[i][b]);
`ifdef PARITY_EN
      exp_q.push_back(vp[i]);
`endif
      @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, t);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic d2_frames(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      d2_in    = 2'b10;
      d2_valid = 1'b1;
      while (!d2_ready && t < 50) begin
        @(negedge clock);
        t++;
      end
      @(negedge clock);
    end
    d2_valid = 1'b0;
    t = 0;
    while (d2_busy && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (d2_busy) begin
      checks++;
      errors++;
      $display("FAIL d2_idle_timeout: busy still %0b", d2_busy);
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_ready", {31'd0, data_ready}, 32'd1);
    check("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
    check("rst_input_bit", {31'd0, input_bit}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {16'd0, frame_count}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single word 0xD5: first bit one cycle after acceptance.
    push_word(0);
    data_valid = 1'b0;
    check("lat_not_yet_valid", {31'd0, bit_valid}, 32'd0);
    check("lat_busy_fifo", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check("lat_first_valid", {31'd0, bit_valid}, 32'd1);
    check("lat_first_bit", {31'd0, input_bit}, 32'd1);
    wait_idle();
    check("d5_count", {16'd0, frame_count}, 32'd1);
    check("d5_busy_after", {31'd0, busy}, 32'd0);
    check("d5_run_len", last_run, FB);
    check("d5_queue_drained", exp_q.size(), 32'd0);

    // Three words with valid held: FIFO fills, frames run back to back.
    push_word(1);
    push_word(2);
    push_word(3);
    check("fifo_full_ready", {31'd0, data_ready}, 32'd0);
    check("fifo_full_busy", {31'd0, busy}, 32'd1);
    data_valid = 1'b0;
    wait_idle();
    check("b2b_count", {16'd0, frame_count}, 32'd4);
    check("b2b_run_len", last_run, 3 * FB);
    check("b2b_queue_drained", exp_q.size(), 32'd0);

    // Reset during bit 4 of 0xFF with 0x01 queued.
    push_word(4);
    push_word(5);
    data_valid = 1'b0;
    check("pushpop_ready", {31'd0, data_ready}, 32'd1);
    repeat (4) @(negedge clock);
    check("pre_rst_valid", {31'd0, bit_valid}, 32'd1);
    check("pre_rst_count", {16'd0, frame_count}, 32'd4);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", {31'd0, bit_valid}, 32'd0);
    check("mid_rst_bit", {31'd0, input_bit}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, data_ready}, 32'd1);
    check("mid_rst_count", {16'd0, frame_count}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      data_in = W'(k * 37);
      @(negedge clock);
    end
    check("post_rst_count", {16'd0, frame_count}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Counter wrap on a narrow instance: 3-bit counter, 2-bit words.
    d2_frames(7);
    check("wrap_count_7", {29'd0, d2_cnt}, 32'd7);
    d2_frames(1);
    check("wrap_count_0", {29'd0, d2_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
